// File: rtl/flash_word_fetcher.sv
// Multi-channel big-endian word fetcher for the byte-wide boot flash.
// Optional single-entry last-word cache: define ROM_WORD_CACHE_EN.
module flash_word_fetcher #(
    parameter int FLASH_AW     = 22,
    parameter int FLASH_DW     = 8,
    parameter int WORD_W       = 16,
    parameter int WAIT_CYCLES  = 3,
    parameter int NUM_CH       = 2,
    localparam int B           = WORD_W / FLASH_DW,
    localparam int WADDR_W     = FLASH_AW - $clog2(B)
) (
    input  logic                      clk32,
    input  logic                      _systemReset,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH*WADDR_W-1:0] reqAddr,
    output logic [NUM_CH-1:0]         ack,
    output logic [WORD_W-1:0]         rdata,
    output logic                      busy,
    output logic [FLASH_AW-1:0]       flashAddr,
    input  logic [FLASH_DW-1:0]       flashData,
    output logic                      _flashCE,
    output logic                      _flashOE,
    output logic                      _flashWE
);

    localparam int BSH = $clog2(B);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int BIW = (B > 1) ? $clog2(B) : 1;

    generate
        if (WORD_W % FLASH_DW != 0) begin : g_bad_width
            $error("WORD_W must be a multiple of FLASH_DW");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [CHW-1:0]     grant;
    logic [CHW-1:0]     gnt_idx;
    logic               gnt_any;
    logic [WADDR_W-1:0] gnt_addr;
    logic [BIW-1:0]     byte_idx;
    logic [WCW-1:0]     wait_cnt;
    logic [WORD_W-1:0]  shreg;
    logic [WORD_W-1:0]  word_next;
    logic               slot_end;
    logic               last_byte;

`ifdef ROM_WORD_CACHE_EN
    logic [WADDR_W-1:0] cache_tag;
    logic [WORD_W-1:0]  cache_word;
    logic               cache_valid;
    logic               hit;

    assign hit = cache_valid && (cache_tag == gnt_addr);
`endif

    // Fixed priority: scanning downwards leaves the lowest request granted.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_addr = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_any  = 1'b1;
                gnt_idx  = CHW'(i);
                gnt_addr = reqAddr[i*WADDR_W +: WADDR_W];
            end
        end
    end

    assign slot_end  = (wait_cnt == WCW'(WAIT_CYCLES));
    assign last_byte = (byte_idx == BIW'(B - 1));
    assign word_next = (shreg << FLASH_DW) | WORD_W'(flashData);
    assign _flashWE  = 1'b1;

    always_ff @(posedge clk32) begin
        if (!_systemReset) state <= IDLE;
        else               state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        _flashCE   = 1'b1;
        _flashOE   = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (gnt_any) begin
`ifdef ROM_WORD_CACHE_EN
                    state_next = hit ? DONE : ACCESS;
`else
                    state_next = ACCESS;
`endif
                end
            end
            ACCESS: begin
                _flashCE = 1'b0;
                _flashOE = 1'b0;
                if (slot_end && last_byte) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ack and rdata are loaded on the edge entering DONE so the word is valid with ack.
    always_ff @(posedge clk32) begin
        if (!_systemReset) begin
            ack         <= '0;
            rdata       <= '0;
            flashAddr   <= '0;
            grant       <= '0;
            byte_idx    <= '0;
            wait_cnt    <= '0;
            shreg       <= '0;
`ifdef ROM_WORD_CACHE_EN
            cache_tag   <= '0;
            cache_word  <= '0;
            cache_valid <= 1'b0;
`endif
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        grant <= gnt_idx;
`ifdef ROM_WORD_CACHE_EN
                        if (hit) begin
                            ack[gnt_idx] <= 1'b1;
                            rdata        <= cache_word;
                        end else
`endif
                        begin
                            flashAddr <= FLASH_AW'(gnt_addr) << BSH;
                            byte_idx  <= '0;
                            wait_cnt  <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (!slot_end) begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end else begin
                        wait_cnt <= '0;
                        shreg    <= word_next;
                        if (last_byte) begin
                            ack[grant] <= 1'b1;
                            rdata      <= word_next;
`ifdef ROM_WORD_CACHE_EN
                            cache_tag   <= flashAddr[FLASH_AW-1:BSH];
                            cache_word  <= word_next;
                            cache_valid <= 1'b1;
`endif
                        end else begin
                            byte_idx  <= byte_idx + BIW'(1);
                            flashAddr <= flashAddr + FLASH_AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_word_fetcher.sv
// Directed bench for flash_word_fetcher: default 16-bit instance plus a
// 32-bit zero-wait instance, both fed by a flash model data = addr[7:0] ^ 0x5A.
module tb_flash_word_fetcher;

    localparam int WAW   = 21;
    localparam int WAW32 = 20;

`ifdef ROM_WORD_CACHE_EN
    localparam int EXP_LAT2 = 11;
    localparam logic EXP_CE11 = 1'b1;
`else
    localparam int EXP_LAT2 = 19;
    localparam logic EXP_CE11 = 1'b0;
`endif

    logic clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    logic              rst_n;
    logic [1:0]        req;
    logic [2*WAW-1:0]  req_addr;
    logic [1:0]        ack;
    logic [15:0]       rdata;
    logic              busy;
    logic [21:0]       faddr;
    logic [7:0]        fdata;
    logic              ce_n, oe_n, we_n;

    logic [1:0]         req32;
    logic [2*WAW32-1:0] req_addr32;
    logic [1:0]         ack32;
    logic [31:0]        rdata32;
    logic               busy32;
    logic [21:0]        faddr32;
    logic [7:0]         fdata32;
    logic               ce32, oe32, we32;

    assign fdata   = faddr[7:0] ^ 8'h5A;
    assign fdata32 = faddr32[7:0] ^ 8'h5A;

    flash_word_fetcher u_dut (
        .clk32(clk32), ._systemReset(rst_n),
        .req(req), .reqAddr(req_addr),
        .ack(ack), .rdata(rdata), .busy(busy),
        .flashAddr(faddr), .flashData(fdata),
        ._flashCE(ce_n), ._flashOE(oe_n), ._flashWE(we_n)
    );

    flash_word_fetcher #(.WORD_W(32), .WAIT_CYCLES(0)) u_dut32 (
        .clk32(clk32), ._systemReset(rst_n),
        .req(req32), .reqAddr(req_addr32),
        .ack(ack32), .rdata(rdata32), .busy(busy32),
        .flashAddr(faddr32), .flashData(fdata32),
        ._flashCE(ce32), ._flashOE(oe32), ._flashWE(we32)
    );

    int cyc = 0;
    int acc = 0;
    int tests = 0;
    int fails = 0;

    always @(posedge clk32) cyc++;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle numbering: the accept edge is cycle 0, the period after it cycle 1.
    task automatic wait_ack(input int dut, input int ch, input int maxc,
                            output int lat);
        lat = -1;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk32);
            if ((dut == 0) ? ack[ch] : ack32[ch]) begin
                lat = cyc - acc + 1;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int seen;
        rst_n      = 1'b0;
        req        = '0;
        req_addr   = '0;
        req32      = '0;
        req_addr32 = '0;

        // Reset state
        repeat (2) @(negedge clk32);
        check("rst_ack", ack, 2'b00);
        check("rst_rdata", rdata, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_ce", ce_n, 1'b1);
        check("rst_oe", oe_n, 1'b1);
        check("rst_we", we_n, 1'b1);
        check("rst_faddr", faddr, 22'h0);
        check("rst32_ce", ce32, 1'b1);
        rst_n = 1'b1;

        // Single ch0 fetch; address change after accept must be ignored
        @(negedge clk32);
        req_addr[0 +: WAW] = 21'h00010;
        req[0] = 1'b1;
        acc = cyc + 1;
        @(negedge clk32);
        check("t2_faddr0", faddr, 22'h000020);
        check("t2_ce", ce_n, 1'b0);
        check("t2_oe", oe_n, 1'b0);
        check("t2_busy", busy, 1'b1);
        req_addr[0 +: WAW] = 21'h00055;
        repeat (4) @(negedge clk32);
        check("t2_faddr1", faddr, 22'h000021);
        wait_ack(0, 0, 20, lat);
        check("t2_lat", lat, 9);
        check("t2_ack", ack, 2'b01);
        check("t2_rdata", rdata, 16'h7A7B);
        req[0] = 1'b0;
        @(negedge clk32);
        check("t2_ack_pulse", ack, 2'b00);
        check("t2_idle_busy", busy, 1'b0);
        check("t2_idle_ce", ce_n, 1'b1);
        check("t2_hold_rdata", rdata, 16'h7A7B);
        check("t2_hold_faddr", faddr, 22'h000021);

        // Simultaneous requests: ch0 first, ch1 ten cycles later
        @(negedge clk32);
        req_addr[0 +: WAW]   = 21'h00010;
        req_addr[WAW +: WAW] = 21'h00040;
        req = 2'b11;
        acc = cyc + 1;
        wait_ack(0, 0, 20, lat);
        check("t3_lat0", lat, 9);
        check("t3_ack0", ack, 2'b01);
        check("t3_rdata0", rdata, 16'h7A7B);
        req[0] = 1'b0;
        wait_ack(0, 1, 20, lat);
        check("t3_lat1", lat, 19);
        check("t3_ack1", ack, 2'b10);
        check("t3_rdata1", rdata, 16'hDADB);
        req[1] = 1'b0;
        @(negedge clk32);

        // Reset in cycle 4 of a ch1 fetch
        req_addr[WAW +: WAW] = 21'h00040;
        req = 2'b10;
        acc = cyc + 1;
        repeat (4) @(negedge clk32);
        check("t4_ce_mid", ce_n, 1'b0);
        rst_n = 1'b0;
        @(negedge clk32);
        check("t4_rst_ce", ce_n, 1'b1);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_ack", ack, 2'b00);
        check("t4_rst_rdata", rdata, 16'h0);
        check("t4_rst_faddr", faddr, 22'h0);
        rst_n = 1'b1;
        req = 2'b00;
        seen = 0;
        repeat (12) begin
            @(negedge clk32);
            if (ack != 2'b00) seen++;
        end
        check("t4_no_ack", seen, 0);
        req_addr[0 +: WAW] = 21'h00010;
        req = 2'b01;
        acc = cyc + 1;
        wait_ack(0, 0, 20, lat);
        check("t4_lat", lat, 9);
        check("t4_rdata", rdata, 16'h7A7B);
        req = 2'b00;

        // Held ch1 request served twice; second may hit the word cache
        @(negedge clk32);
        rst_n = 1'b0;
        @(negedge clk32);
        rst_n = 1'b1;
        req_addr[WAW +: WAW] = 21'h00010;
        req = 2'b10;
        acc = cyc + 1;
        wait_ack(0, 1, 20, lat);
        check("t5_lat1", lat, 9);
        check("t5_rdata1", rdata, 16'h7A7B);
        @(negedge clk32);
        check("t5_ack_pulse", ack, 2'b00);
        @(negedge clk32);
        check("t5_ce_c11", ce_n, EXP_CE11);
        if (ack[1]) lat = cyc - acc + 1;
        else        wait_ack(0, 1, 20, lat);
        check("t5_lat2", lat, EXP_LAT2);
        check("t5_rdata2", rdata, 16'h7A7B);
        req = 2'b00;
        @(negedge clk32);

        // 32-bit word, zero wait states
        req_addr32[0 +: WAW32] = 20'h00004;
        req32 = 2'b01;
        acc = cyc + 1;
        @(negedge clk32);
        check("t6_faddr0", faddr32, 22'h000010);
        wait_ack(1, 0, 20, lat);
        check("t6_lat", lat, 5);
        check("t6_faddr3", faddr32, 22'h000013);
        check("t6_rdata", rdata32, 32'h4A4B4849);
        req32 = 2'b00;
        @(negedge clk32);
        check("t6_busy", busy32, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
